// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a pending-write scoreboard and
// a sequential clear engine. Sits between decode (reads, reservations) and
// writeback (writes).
//
// Parameters:
//   DATA_W   - data width in bits
//   ADDR_W   - address width, DEPTH = 2**ADDR_W entries
//   BYPASS   - 1: a same-cycle write is visible on the read ports and busy outputs
//   ZERO_REG - 1: entry 0 always reads 0, ignores writes/reserves, never busy
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   rst                 asynchronous active-low reset
//   rd_addr1/rd_addr2   read addresses
//   rd_data1/rd_data2   combinational read data
//   busy1/busy2         scoreboard bits for the read addresses
//   wr_en/wr_addr/wr_data  write port (writeback), clears the busy bit
//   rsv_en/rsv_addr     reserve port (decode), sets the busy bit
//   clr_req             pulse: start a sweep that zeroes every entry
//   clr_busy            high while the sweep runs (registered)
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;

    logic idle;
    logic wr_ok;
    logic rsv_ok;

    assign idle = (state_reg == ST_IDLE);

    // A clear request in IDLE takes priority: the same-cycle write and
    // reserve are dropped. Entry 0 is read-only when ZERO_REG is set.
    assign wr_ok  = wr_en  && idle && !clr_req && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && idle && !clr_req && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Clear FSM: next state and sweep counter
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;  // wraps back to 0 after the last entry
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // clr_busy is a decode of the one-bit state register, so it has no
    // combinational dependence on any input.
    assign clr_busy = (state_reg == ST_CLEAR);

    // Storage and scoreboard. Reserve is applied after write so a same-cycle
    // write+reserve to one entry leaves it busy with the new data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            mem_reg[cnt_reg]  <= '0;
            busy_reg[cnt_reg] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_reg[wr_addr]  <= wr_data;
                busy_reg[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy_reg[rsv_addr] <= 1'b1;
            end
        end
    end

    // Read ports, built identically for both addresses
    logic [ADDR_W-1:0] rd_addr_arr [2];
    logic [DATA_W-1:0] rd_data_arr [2];
    logic              busy_arr    [2];

    assign rd_addr_arr[0] = rd_addr1;
    assign rd_addr_arr[1] = rd_addr2;
    assign rd_data1       = rd_data_arr[0];
    assign rd_data2       = rd_data_arr[1];
    assign busy1          = busy_arr[0];
    assign busy2          = busy_arr[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            logic is_zero;
            logic byp_hit;
            logic rsv_hit;

            assign is_zero = (ZERO_REG != 0) && (rd_addr_arr[gi] == '0);
            // Bypass follows the raw write request in IDLE; never in CLEAR.
            assign byp_hit = (BYPASS != 0) && wr_en && idle && (wr_addr == rd_addr_arr[gi]);
            assign rsv_hit = rsv_en && (rsv_addr == rd_addr_arr[gi]);

            always_comb begin
                rd_data_arr[gi] = mem_reg[rd_addr_arr[gi]];
                busy_arr[gi]    = busy_reg[rd_addr_arr[gi]];
                if (is_zero) begin
                    rd_data_arr[gi] = '0;
                    busy_arr[gi]    = 1'b0;
                end else if (byp_hit) begin
                    rd_data_arr[gi] = wr_data;
                    // A pending write clears busy early unless the same entry
                    // is being re-reserved this cycle.
                    if (!rsv_hit) begin
                        busy_arr[gi] = 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb. Three instances share one stimulus stream:
// cfg0 BYPASS=1/ZERO_REG=0, cfg1 BYPASS=0/ZERO_REG=0, cfg2 BYPASS=1/ZERO_REG=1.
// A behavioural model of the entries, busy bits and sweep position is checked
// against all outputs every cycle; directed steps add literal expectations.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [15:0] wr_data;
    logic        wr_en, rsv_en, clr_req;

    logic [15:0] d1 [3];
    logic [15:0] d2 [3];
    logic        b1 [3];
    logic        b2 [3];
    logic        cb [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) u_byp (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[0]), .rd_data2(d2[0]), .busy1(b1[0]), .busy2(b2[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(cb[0])
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[1]), .rd_data2(d2[1]), .busy1(b1[1]), .busy2(b2[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(cb[1])
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1)) u_zero (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1[2]), .rd_data2(d2[2]), .busy1(b1[2]), .busy2(b2[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(cb[2])
    );

    // ---------------- behavioural model ----------------
    int          byp_cfg  [3] = '{1, 0, 1};
    int          zero_cfg [3] = '{0, 0, 1};
    logic [15:0] m_mem  [3][16];
    logic        m_busy [3][16];
    bit          in_clear;
    int          sweep_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 16; a++) begin
                m_mem[c][a]  = '0;
                m_busy[c][a] = 1'b0;
            end
        end
        in_clear  = 1'b0;
        sweep_idx = 0;
    endtask

    task automatic model_step();
        if (in_clear) begin
            for (int c = 0; c < 3; c++) begin
                m_mem[c][sweep_idx]  = '0;
                m_busy[c][sweep_idx] = 1'b0;
            end
            if (sweep_idx == 15) in_clear = 1'b0;
            sweep_idx = (sweep_idx + 1) % 16;
        end else if (clr_req) begin
            in_clear  = 1'b1;
            sweep_idx = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (wr_en && !(zero_cfg[c] != 0 && wr_addr == 4'd0)) begin
                    m_mem[c][wr_addr]  = wr_data;
                    m_busy[c][wr_addr] = 1'b0;
                end
                if (rsv_en && !(zero_cfg[c] != 0 && rsv_addr == 4'd0)) begin
                    m_busy[c][rsv_addr] = 1'b1;
                end
            end
        end
    endtask

    function automatic bit bypassing(int c, logic [3:0] a);
        return (byp_cfg[c] != 0) && wr_en && !in_clear && (wr_addr == a);
    endfunction

    function automatic logic [15:0] exp_data(int c, logic [3:0] a);
        if (!rst) return 16'h0;
        if (zero_cfg[c] != 0 && a == 4'd0) return 16'h0;
        if (bypassing(c, a)) return wr_data;
        return m_mem[c][a];
    endfunction

    function automatic logic exp_busy(int c, logic [3:0] a);
        if (!rst) return 1'b0;
        if (zero_cfg[c] != 0 && a == 4'd0) return 1'b0;
        if (bypassing(c, a) && !(rsv_en && rsv_addr == a)) return 1'b0;
        return m_busy[c][a];
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            for (int c = 0; c < 3; c++) begin
                check($sformatf("cfg%0d rd_data1[%0d]", c, rd_addr1), d1[c], exp_data(c, rd_addr1));
                check($sformatf("cfg%0d rd_data2[%0d]", c, rd_addr2), d2[c], exp_data(c, rd_addr2));
                check($sformatf("cfg%0d busy1[%0d]", c, rd_addr1), b1[c], exp_busy(c, rd_addr1));
                check($sformatf("cfg%0d busy2[%0d]", c, rd_addr2), b2[c], exp_busy(c, rd_addr2));
                check($sformatf("cfg%0d clr_busy", c), cb[c], (rst && in_clear) ? 1 : 0);
            end
            @(posedge clk);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        idle_inputs();
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset contents on both ports
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            #1;
            check("reset rd_data1", d1[0], 16'h0000);
            check("reset busy1", b1[0], 0);
            check("reset rd_data2 nobyp", d2[1], 16'h0000);
        end
        $display("[TB] reset contents read on both ports");

        // write with bypass vs. without
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr1 = 4'd5;
        #1;
        check("bypass same cycle", d1[0], 16'hBEEF);
        check("no-bypass same cycle", d1[1], 16'h0000);
        next_cycle();
        idle_inputs();
        #1;
        check("no-bypass next cycle", d1[1], 16'hBEEF);
        check("bypass next cycle", d1[0], 16'hBEEF);
        $display("[TB] write r5=beef");

        // reserve r3, then write it
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 4'd3; rd_addr1 = 4'd3;
        #1;
        check("busy before reserve edge", b1[0], 0);
        next_cycle();
        idle_inputs();
        #1;
        check("busy after reserve", b1[0], 1);
        check("busy after reserve nobyp", b1[1], 1);
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        #1;
        check("busy bypassed in write cycle", b1[0], 0);
        check("busy held in write cycle nobyp", b1[1], 1);
        next_cycle();
        idle_inputs();
        #1;
        check("busy after write", b1[0], 0);
        check("busy after write nobyp", b1[1], 0);
        check("r3 data nobyp", d1[1], 16'h1234);
        $display("[TB] reserve r3, write r3=1234");

        // reserve and write r7 together
        next_cycle();
        wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 4'd7; rsv_addr = 4'd7;
        wr_data = 16'h7777; rd_addr1 = 4'd7;
        next_cycle();
        idle_inputs();
        #1;
        check("r7 busy after write+reserve", b1[0], 1);
        check("r7 data after write+reserve", d1[0], 16'h7777);
        $display("[TB] write+reserve r7=7777");

        // entry 0 with and without ZERO_REG
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr1 = 4'd0;
        #1;
        check("zero reg data same cycle", d1[2], 16'h0000);
        check("zero reg busy same cycle", b1[2], 0);
        check("r0 bypass data cfg0", d1[0], 16'hFFFF);
        next_cycle();
        idle_inputs();
        #1;
        check("zero reg data after", d1[2], 16'h0000);
        check("zero reg busy after", b1[2], 0);
        check("r0 busy cfg0", b1[0], 1);
        $display("[TB] write+reserve r0=ffff");

        // fill, then sweep with a competing write to r2
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
        end
        next_cycle();
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hDEAD;
        rd_addr1 = 4'd9; rd_addr2 = 4'd15;
        #1;
        check("clr_busy low in request cycle", cb[0], 0);
        $display("[TB] filled r0..r15, clear request with write r2=dead");
        next_cycle();
        clr_req = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
        rd_addr1 = 4'd2;
        #1;
        n = 0;
        while (cb[0] === 1'b1 && n < 40) begin
            if (n == 0) check("r2 write dropped by clear", d1[0], 16'h1002);
            if (n == 10) check("write ignored during sweep", d1[0], 16'h0000);
            if (n == 14) check("r15 unswept at cycle 14", d2[0], 16'h100F);
            n++;
            next_cycle();
            rd_addr1 = 4'd4;
            #1;
        end
        check("sweep length", n, 16);
        // this cycle's write to r4 is the first one accepted after the sweep
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1;
            check("after sweep cfg0", d1[0], (i == 4) ? 16'h4444 : 16'h0000);
            check("after sweep busy cfg0", b1[0], 0);
            check("after sweep cfg2", d1[2], (i == 4) ? 16'h4444 : 16'h0000);
        end
        $display("[TB] sweep finished after %0d cycles", n);

        // reset in the middle of a sweep
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hABCD; rd_addr1 = 4'd9;
        next_cycle();
        idle_inputs();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        repeat (6) next_cycle();
        #1;
        check("r9 before abort", d1[0], 16'hABCD);
        check("clr_busy before abort", cb[0], 1);
        rst = 1'b0;
        #1;
        check("clr_busy on abort", cb[0], 0);
        check("r9 on abort", d1[0], 16'h0000);
        check("r9 on abort nobyp", d1[1], 16'h0000);
        next_cycle();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5555;
        next_cycle();
        idle_inputs();
        #1;
        check("write after reset release", d1[1], 16'h5555);
        check("clr_busy after reset", cb[1], 0);
        $display("[TB] reset during sweep, write r9=5555 afterwards");

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 16'($urandom);
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            clr_req  = ($urandom_range(0, 149) == 0);
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr2 = ($urandom_range(0, 2) == 0) ? rsv_addr : 4'($urandom_range(0, 15));
            if (clr_req) $display("[TB] random cycle %0d: clear request", k);
        end
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
